flow_ctrl_fsm: RTL and testbench

Parametrised flow-control state machine that sequences the switch datapath through RESET, INIT, IDLE, ACTIVE and ERROR. It captures per-FIFO low/high watermark thresholds for NUM_FIFOS FIFOs and rejects inconsistent configurations. It tracks FIFO occupancy and records which FIFO raised an error. It sits beside the FIFO array and drives the watermark registers and the status outputs.

---
 rtl/flow_ctrl_pkg.sv | 24 ++
 rtl/flow_ctrl_if.sv | 36 +++
 rtl/flow_ctrl_thr_check.sv | 23 ++
 rtl/flow_ctrl_fsm.sv | 121 ++++++++++++
 tb/tb_flow_ctrl_fsm.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/flow_ctrl_pkg.sv
// Shared definitions for the flow-control FSM: one-hot state codes, default
// build parameters and the threshold packing helper.
package flow_ctrl_pkg;

    localparam int STATE_W = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    localparam int DEF_NUM_FIFOS = 5;
    localparam int DEF_TH_W      = 5;
    localparam int DEF_IDLE_DLY  = 4;

    // Bit offset of FIFO idx's field inside a packed threshold vector.
    function automatic int thr_lsb(input int idx, input int th_w);
        return idx * th_w;
    endfunction

endpackage

// File: rtl/flow_ctrl_if.sv
// Bundle of configuration, FIFO status and supervisor status signals shared
// between the switch control logic (master) and the flow-control FSM (slave).
interface flow_ctrl_if
    import flow_ctrl_pkg::*;
#(
    parameter int NUM_FIFOS = DEF_NUM_FIFOS,
    parameter int TH_W      = DEF_TH_W
);
    logic                      init;
    logic                      err_clear;
    logic [NUM_FIFOS*TH_W-1:0] thr_low_in;
    logic [NUM_FIFOS*TH_W-1:0] thr_high_in;
    logic [NUM_FIFOS-1:0]      empties;
    logic [NUM_FIFOS-1:0]      errors;

    logic [NUM_FIFOS*TH_W-1:0] thr_low;
    logic [NUM_FIFOS*TH_W-1:0] thr_high;
    logic                      idle_out;
    logic                      active_out;
    logic                      error_out;
    logic                      cfg_err;
    logic [NUM_FIFOS-1:0]      err_src;
    logic [STATE_W-1:0]        state_out;

    modport master (
        output init, err_clear, thr_low_in, thr_high_in, empties, errors,
        input  thr_low, thr_high, idle_out, active_out, error_out,
               cfg_err, err_src, state_out
    );

    modport slave (
        input  init, err_clear, thr_low_in, thr_high_in, empties, errors,
        output thr_low, thr_high, idle_out, active_out, error_out,
               cfg_err, err_src, state_out
    );
endinterface

// File: rtl/flow_ctrl_thr_check.sv
// Combinational consistency check: flags any FIFO whose low watermark is
// above its high watermark (unsigned compare).
module flow_ctrl_thr_check
    import flow_ctrl_pkg::*;
#(
    parameter int NUM_FIFOS = DEF_NUM_FIFOS,
    parameter int TH_W      = DEF_TH_W
) (
    input  logic [NUM_FIFOS*TH_W-1:0] thr_low,
    input  logic [NUM_FIFOS*TH_W-1:0] thr_high,
    output logic                      bad
);

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (thr_low[thr_lsb(i, TH_W) +: TH_W] > thr_high[thr_lsb(i, TH_W) +: TH_W]) begin
                bad = 1'b1;
            end
        end
    end

endmodule

// File: rtl/flow_ctrl_fsm.sv
// Flow-control supervisor: sequences RESET/INIT/IDLE/ACTIVE/ERROR, holds the
// watermark registers and records configuration and FIFO error sources.
module flow_ctrl_fsm
    import flow_ctrl_pkg::*;
#(
    parameter int NUM_FIFOS = DEF_NUM_FIFOS,
    parameter int TH_W      = DEF_TH_W,
    parameter int IDLE_DLY  = DEF_IDLE_DLY
) (
    input logic       clk,
    input logic       reset,
    flow_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(IDLE_DLY + 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(IDLE_DLY - 1);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          drain_q, drain_d;
    logic [NUM_FIFOS-1:0]      src_q, src_d;
    logic                      cfg_q, cfg_d;
    logic                      load_thr;
    logic                      cfg_bad;
    logic                      all_empty;
    logic [NUM_FIFOS*TH_W-1:0] thr_low_q, thr_high_q;

    flow_ctrl_thr_check #(
        .NUM_FIFOS (NUM_FIFOS),
        .TH_W      (TH_W)
    ) u_thr_check (
        .thr_low  (bus.thr_low_in),
        .thr_high (bus.thr_high_in),
        .bad      (cfg_bad)
    );

    assign all_empty = &bus.empties;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            drain_q    <= '0;
            src_q      <= '0;
            cfg_q      <= 1'b0;
            thr_low_q  <= '0;
            thr_high_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            src_q   <= src_d;
            cfg_q   <= cfg_d;
            if (load_thr) begin
                thr_low_q  <= bus.thr_low_in;
                thr_high_q <= bus.thr_high_in;
            end
        end
    end

    // The drain counter defaults to zero so it is cleared on every non-empty
    // cycle and whenever ACTIVE is (re)entered.
    always_comb begin
        state_d  = state_q;
        drain_d  = '0;
        src_d    = src_q;
        cfg_d    = cfg_q;
        load_thr = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                load_thr = 1'b1;
                if (!bus.init) begin
                    state_d = cfg_bad ? ST_ERROR : ST_IDLE;
                    cfg_d   = cfg_bad;
                end
            end
            ST_IDLE: begin
                if (bus.init) begin
                    state_d = ST_INIT;
                end else if (|bus.errors) begin
                    state_d = ST_ERROR;
                    src_d   = bus.errors;
                end else if (!all_empty) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (bus.init) begin
                    state_d = ST_INIT;
                end else if (|bus.errors) begin
                    state_d = ST_ERROR;
                    src_d   = bus.errors;
                end else if (all_empty) begin
                    if (drain_q == DRAIN_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        drain_d = drain_q + CNT_W'(1);
                    end
                end
            end
            ST_ERROR: begin
                if (bus.err_clear) begin
                    state_d = ST_INIT;
                    src_d   = '0;
                    cfg_d   = 1'b0;
                end else begin
                    src_d = src_q | bus.errors;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    assign bus.thr_low    = thr_low_q;
    assign bus.thr_high   = thr_high_q;
    assign bus.state_out  = state_q;
    assign bus.idle_out   = (state_q == ST_IDLE);
    assign bus.active_out = (state_q == ST_ACTIVE);
    assign bus.error_out  = (state_q == ST_ERROR);
    assign bus.cfg_err    = cfg_q;
    assign bus.err_src    = src_q;

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// Directed plus randomized bench for flow_ctrl_fsm, compared every cycle
// against a behavioural model of the supervisor rules.
module tb_flow_ctrl_fsm;
    import flow_ctrl_pkg::*;

    localparam int NF  = 5;
    localparam int W   = 5;
    localparam int DLY = 4;

    localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3, M_ERROR = 4, M_ILLEGAL = 5;

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;

    int            m_state;
    int            m_empty_run;
    logic [NF-1:0] m_src;
    logic          m_cfg;
    logic [NF*W-1:0] m_low, m_high;

    flow_ctrl_if #(.NUM_FIFOS(NF), .TH_W(W)) ifc ();

    flow_ctrl_fsm #(.NUM_FIFOS(NF), .TH_W(W), .IDLE_DLY(DLY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] exp_state(input int m);
        case (m)
            M_RESET:  return 5'b00001;
            M_INIT:   return 5'b00010;
            M_IDLE:   return 5'b00100;
            M_ACTIVE: return 5'b01000;
            M_ERROR:  return 5'b10000;
            default:  return 5'b00110;
        endcase
    endfunction

    task automatic model_reset();
        m_state = M_RESET; m_empty_run = 0; m_src = '0; m_cfg = 1'b0;
        m_low = '0; m_high = '0;
    endtask

    // Applies the supervisor rules to the inputs sampled on this edge.
    task automatic model_step();
        bit bad = 0;
        int nxt = m_state;
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NF; i++) begin
            int lo = int'(ifc.thr_low_in[i*W +: W]);
            int hi = int'(ifc.thr_high_in[i*W +: W]);
            if (lo > hi) bad = 1;
        end
        case (m_state)
            M_RESET: nxt = M_INIT;
            M_INIT: begin
                m_low = ifc.thr_low_in; m_high = ifc.thr_high_in;
                if (!ifc.init) begin
                    nxt = bad ? M_ERROR : M_IDLE;
                    m_cfg = bad;
                end
            end
            M_IDLE, M_ACTIVE: begin
                if (ifc.init) nxt = M_INIT;
                else if (ifc.errors != 0) begin
                    nxt = M_ERROR; m_src = ifc.errors;
                end else if (m_state == M_IDLE) begin
                    if (ifc.empties != {NF{1'b1}}) begin
                        nxt = M_ACTIVE; m_empty_run = 0;
                    end
                end else if (ifc.empties == {NF{1'b1}}) begin
                    m_empty_run++;
                    if (m_empty_run == DLY) nxt = M_IDLE;
                end else begin
                    m_empty_run = 0;
                end
            end
            M_ERROR: begin
                if (ifc.err_clear) begin
                    nxt = M_INIT; m_src = '0; m_cfg = 1'b0;
                end else begin
                    m_src = m_src | ifc.errors;
                end
            end
            default: nxt = M_RESET;
        endcase
        m_state = nxt;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        check_val({tag, ".state"},  32'(ifc.state_out),  32'(exp_state(m_state)));
        check_val({tag, ".idle"},   32'(ifc.idle_out),   32'(m_state == M_IDLE));
        check_val({tag, ".active"}, 32'(ifc.active_out), 32'(m_state == M_ACTIVE));
        check_val({tag, ".error"},  32'(ifc.error_out),  32'(m_state == M_ERROR));
        check_val({tag, ".cfg"},    32'(ifc.cfg_err),    32'(m_cfg));
        check_val({tag, ".src"},    32'(ifc.err_src),    32'(m_src));
        check_val({tag, ".low"},    32'(ifc.thr_low),    32'(m_low));
        check_val({tag, ".high"},   32'(ifc.thr_high),   32'(m_high));
    endtask

    task automatic apply_stimulus(input logic ini, input logic clr, input logic [NF*W-1:0] lo,
                                  input logic [NF*W-1:0] hi, input logic [NF-1:0] emp,
                                  input logic [NF-1:0] err);
        ifc.init = ini; ifc.err_clear = clr; ifc.thr_low_in = lo; ifc.thr_high_in = hi;
        ifc.empties = emp; ifc.errors = err;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_output(tag);
    endtask

    logic [NF*W-1:0] good_low, good_high, bad_low;
    localparam logic [NF-1:0] ALL_E = {NF{1'b1}};

    initial begin
        good_low  = {NF{5'd2}};
        good_high = {NF{5'd20}};
        bad_low   = good_low;
        bad_low[3*W +: W] = 5'd9;

        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, '0, '0, ALL_E, '0);
        model_reset();
        #2;
        check_output("reset");
        tick("reset_hold");

        reset = 1'b0;
        apply_stimulus(1'b1, 1'b0, good_low, good_high, ALL_E, '0);
        tick("to_init");
        for (int i = 0; i < 3; i++) tick("init_hold");
        ifc.init = 1'b0;
        tick("init_exit");
        check_val("thr_low_all2", 32'(ifc.thr_low), 32'(good_low));
        check_val("idle_after_init", 32'(ifc.state_out), 32'(5'b00100));

        // Inconsistent thresholds on FIFO 3
        apply_stimulus(1'b1, 1'b0, bad_low, {NF{5'd4}} | good_high, ALL_E, '0);
        ifc.thr_high_in[3*W +: W] = 5'd4;
        tick("bad_init");
        ifc.init = 1'b0;
        tick("bad_exit");
        check_val("cfg_err_set", 32'(ifc.cfg_err), 32'd1);
        ifc.err_clear = 1'b1;
        tick("cfg_clear");
        apply_stimulus(1'b0, 1'b0, good_low, good_high, ALL_E, '0);
        tick("back_idle");

        // Drain window: 3 empty, 1 busy, 4 empty
        ifc.empties = 5'b11110;
        tick("to_active");
        ifc.empties = ALL_E;
        for (int i = 0; i < 3; i++) tick("drain_a");
        ifc.empties = 5'b10111;
        tick("drain_busy");
        ifc.empties = ALL_E;
        for (int i = 0; i < 3; i++) tick("drain_b");
        check_val("still_active", 32'(ifc.active_out), 32'd1);
        tick("drain_done");
        check_val("idle_on_4th", 32'(ifc.idle_out), 32'd1);

        // Error sources accumulate in ERROR
        ifc.empties = 5'b01111;
        tick("to_active2");
        ifc.errors = 5'b00100;
        tick("err_enter");
        ifc.errors = 5'b00001;
        tick("err_accum");
        ifc.errors = '0;
        tick("err_hold");
        ifc.init = 1'b1;
        tick("err_ignores_init");
        check_val("err_src_or", 32'(ifc.err_src), 32'(5'b00101));
        apply_stimulus(1'b0, 1'b1, good_low, good_high, ALL_E, 5'b00010);
        tick("err_clear");
        ifc.err_clear = 1'b0;
        ifc.errors = '0;
        tick("idle_again");

        // init beats errors in ACTIVE
        ifc.empties = 5'b11101;
        tick("to_active3");
        ifc.init = 1'b1;
        ifc.errors = 5'b01000;
        tick("init_wins");
        check_val("init_wins_src", 32'(ifc.err_src), 32'd0);
        apply_stimulus(1'b0, 1'b0, good_low, good_high, 5'b11011, '0);
        tick("idle4");
        tick("to_active4");

        // Asynchronous reset between edges
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_output("async_reset");
        #2 reset = 1'b0;
        ifc.empties = ALL_E;
        tick("rst_to_init");
        tick("rst_to_idle");

        // Illegal state code recovers through RESET
        force dut.state_q = state_t'(5'b00110);
        #1 release dut.state_q;
        m_state = M_ILLEGAL;
        check_output("illegal");
        tick("illegal_recover");

        for (int n = 0; n < 400; n++) begin
            logic [NF*W-1:0] lo = ifc.thr_low_in;
            logic [NF*W-1:0] hi = ifc.thr_high_in;
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < NF; i++) begin
                    lo[i*W +: W] = W'($urandom_range(0, 15));
                    hi[i*W +: W] = W'($urandom_range(10, 31));
                    if ($urandom_range(0, 9) == 0) lo[i*W +: W] = W'($urandom);
                end
            end
            apply_stimulus($urandom_range(0, 15) == 0,
                           $urandom_range(0, 3) == 0,
                           lo, hi,
                           ($urandom_range(0, 1) == 0) ? ALL_E : NF'($urandom),
                           ($urandom_range(0, 7) == 0) ? NF'($urandom) : '0);
            tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
